// File: rtl/mult_seq_nibble_pkg.sv
// Shared types and helpers for the nibble-serial multiplier.
//   state_e     : controller states (IDLE, CALC, DONE)
//   NIB_W       : width of one operand slice fed to the 4x4 multiplier
//   step_count  : number of nibble-pair steps for a given nibble count
//   step_cnt_w  : width of the step counter for a given nibble count
package mult_seq_nibble_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  function automatic int step_count(input int n_nib);
    return n_nib * n_nib;
  endfunction

  // A single-nibble operand still needs a one-bit counter.
  function automatic int step_cnt_w(input int n_nib);
    return (n_nib * n_nib > 1) ? $clog2(n_nib * n_nib) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_nibble_if.sv
// Bundle of the multiplier's handshake and side-multiplier signals.
//   in_valid/in_ready/in_a/in_b     : operand channel (into the block)
//   nib_a/nib_b/nib_prod            : link to the external 4x4 multiplier
//   out_valid/out_ready/out_prod    : product channel (out of the block)
//   busy                            : block is in CALC or DONE
// slave  : the multiplier block itself
// master : its surroundings (operand source, consumer, 4x4 multiplier)
interface mult_seq_nibble_if #(
  parameter int IN_W = 8
);

  logic                                  in_valid;
  logic                                  in_ready;
  logic [IN_W-1:0]                       in_a;
  logic [IN_W-1:0]                       in_b;
  logic [mult_seq_nibble_pkg::NIB_W-1:0] nib_a;
  logic [mult_seq_nibble_pkg::NIB_W-1:0] nib_b;
  logic [2*mult_seq_nibble_pkg::NIB_W-1:0] nib_prod;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [2*IN_W-1:0]                     out_prod;
  logic                                  busy;

  modport slave (
    input  in_valid, in_a, in_b, nib_prod, out_ready,
    output in_ready, nib_a, nib_b, out_valid, out_prod, busy
  );

  modport master (
    output in_valid, in_a, in_b, nib_prod, out_ready,
    input  in_ready, nib_a, nib_b, out_valid, out_prod, busy
  );

endinterface

// File: rtl/mult_seq_nibble_nib_select.sv
// Nibble-pair selector for step k of the nibble-serial multiply.
//   a_i, b_i  : latched operands
//   k_i       : step index, i = k mod N_NIB (a slice), j = k div N_NIB (b slice)
//   nib_a_o   : a[4i+3:4i]
//   nib_b_o   : b[4j+3:4j]
//   shift_o   : weight of the partial product, 4*(i+j)
module mult_seq_nibble_nib_select
  import mult_seq_nibble_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int N_NIB = IN_W / NIB_W,
  parameter int K_W   = step_cnt_w(N_NIB),
  parameter int SH_W  = $clog2(2 * IN_W)
) (
  input  logic [IN_W-1:0]  a_i,
  input  logic [IN_W-1:0]  b_i,
  input  logic [K_W-1:0]   k_i,
  output logic [NIB_W-1:0] nib_a_o,
  output logic [NIB_W-1:0] nib_b_o,
  output logic [SH_W-1:0]  shift_o
);

  always_comb begin : sel
    int i;
    int j;
    i = int'(k_i) % N_NIB;
    j = int'(k_i) / N_NIB;
    // Shifting instead of a variable part-select keeps index widths trivial.
    nib_a_o = NIB_W'(a_i >> (NIB_W * i));
    nib_b_o = NIB_W'(b_i >> (NIB_W * j));
    shift_o = SH_W'(NIB_W * (i + j));
  end

endmodule

// File: rtl/mult_seq_nibble.sv
// Sequential unsigned IN_W x IN_W multiplier that time-shares one external
// 4x4 -> 8 multiplier. Operands are latched on the input handshake, one
// nibble pair per cycle is presented on nib_a/nib_b, and each returned
// partial product is shifted into place and accumulated. The full product
// is then held on out_prod until the consumer takes it.
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : operand channel, 4x4 multiplier link, product channel, busy
module mult_seq_nibble
  import mult_seq_nibble_pkg::*;
#(
  parameter int IN_W = 8
) (
  input logic              clk,
  input logic              rst,
  mult_seq_nibble_if.slave bus
);

  localparam int N_NIB  = IN_W / NIB_W;
  localparam int N_STEP = step_count(N_NIB);
  localparam int K_W    = step_cnt_w(N_NIB);
  localparam int P_W    = 2 * IN_W;
  localparam int SH_W   = $clog2(P_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_STEP - 1);

  state_e           state_q;
  logic [IN_W-1:0]  a_q, b_q;
  logic [K_W-1:0]   k_q;
  logic [P_W-1:0]   acc_q;
  logic [P_W-1:0]   out_prod_q;
  logic [NIB_W-1:0] nib_a_q, nib_b_q;
  logic [SH_W-1:0]  shift_q;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [IN_W-1:0]  a_d, b_d;
  logic [K_W-1:0]   k_d;
  logic             nib_ld_d;
  logic [NIB_W-1:0] sel_nib_a, sel_nib_b;
  logic [SH_W-1:0]  sel_shift;
  logic [P_W-1:0]   acc_sum;

  // The nibble for the upcoming step is chosen from next-state operands and
  // counter so that nib_a/nib_b come straight out of flops.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    nib_ld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.in_a;
          b_d      = bus.in_b;
          k_d      = '0;
          nib_ld_d = 1'b1;
        end
      end
      CALC: begin
        if (k_q != K_LAST) begin
          k_d      = k_q + K_W'(1);
          nib_ld_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  mult_seq_nibble_nib_select #(
    .IN_W  (IN_W),
    .N_NIB (N_NIB),
    .K_W   (K_W),
    .SH_W  (SH_W)
  ) u_nib_select (
    .a_i     (a_d),
    .b_i     (b_d),
    .k_i     (k_d),
    .nib_a_o (sel_nib_a),
    .nib_b_o (sel_nib_b),
    .shift_o (sel_shift)
  );

  // Partial product of the current step, placed at weight 4*(i+j).
  // The full product fits P_W bits, so the sum cannot overflow.
  assign acc_sum = acc_q + (P_W'(bus.nib_prod) << shift_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_prod_q  <= '0;
      nib_a_q     <= '0;
      nib_b_q     <= '0;
      shift_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      // Outside an active step the multiplier inputs rest at zero.
      nib_a_q <= nib_ld_d ? sel_nib_a : '0;
      nib_b_q <= nib_ld_d ? sel_nib_b : '0;
      shift_q <= nib_ld_d ? sel_shift : '0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_sum;
          if (k_q == K_LAST) begin
            out_prod_q  <= acc_sum;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = out_prod_q;
  assign bus.busy      = busy_q;
  assign bus.nib_a     = nib_a_q;
  assign bus.nib_b     = nib_b_q;

endmodule

// File: tb/tb_mult_seq_nibble.sv
// Directed bench for mult_seq_nibble; the bench plays the parent and
// supplies the 4x4 multiplier on nib_prod.
module tb_mult_seq_nibble;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mult_seq_nibble_if #(.IN_W(8)) bus ();

  assign bus.nib_prod = 8'(bus.nib_a) * 8'(bus.nib_b);

  mult_seq_nibble #(.IN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge of cycle T+1.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL start_op_ready got %b required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got %b required 100", {bus.in_ready, bus.out_valid, bus.busy});
    end
    checks++;
    if ({bus.out_prod, bus.nib_a, bus.nib_b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h required 000000", {bus.out_prod, bus.nib_a, bus.nib_b});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] exp_a [4] = '{4'h2, 4'h1, 4'h2, 4'h1};
    logic [3:0] exp_b [4] = '{4'h4, 4'h4, 4'h3, 4'h3};
    start_op(8'h12, 8'h34);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b001) begin
        errors++;
        $display("FAIL basic_flags step %0d got %b required 001", k, {bus.in_ready, bus.out_valid, bus.busy});
      end
      checks++;
      if ({bus.nib_a, bus.nib_b} !== {exp_a[k], exp_b[k]}) begin
        errors++;
        $display("FAIL basic_nibs step %0d got %h required %h", k, {bus.nib_a, bus.nib_b}, {exp_a[k], exp_b[k]});
      end
      tick();
    end
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b101) begin
      errors++;
      $display("FAIL basic_done_flags got %b required 101", {bus.out_valid, bus.in_ready, bus.busy});
    end
    checks++;
    if (bus.out_prod !== 16'h03A8) begin
      errors++;
      $display("FAIL basic_prod got %h required 03a8", bus.out_prod);
    end
    checks++;
    if ({bus.nib_a, bus.nib_b} !== 8'h00) begin
      errors++;
      $display("FAIL basic_done_nibs got %h required 00", {bus.nib_a, bus.nib_b});
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_release got %b required 01", {bus.out_valid, bus.in_ready});
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_ones();
    bus.out_ready = 1'b1;
    start_op(8'hFF, 8'hFF);
    repeat (4) tick();
    checks++;
    if ({bus.out_valid, bus.out_prod} !== {1'b1, 16'hFE01}) begin
      errors++;
      $display("FAIL ones_prod got %b/%h required 1/fe01", bus.out_valid, bus.out_prod);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ones_one_cycle got %b required 01", {bus.out_valid, bus.in_ready});
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_zero();
    bus.out_ready = 1'b1;
    start_op(8'h00, 8'hA5);
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_early got %b required 0", bus.out_valid);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_prod} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL zero_prod got %b/%h required 1/0000", bus.out_valid, bus.out_prod);
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    start_op(8'h80, 8'h02);
    repeat (4) tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_prod} !== {2'b10, 16'h0100}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got %b%b/%h required 10/0100", c, bus.out_valid, bus.in_ready, bus.out_prod);
      end
      // Operand offers during the stall must be ignored.
      bus.in_valid = c[0];
      bus.in_a     = 8'h11;
      bus.in_b     = 8'h22;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      errors++;
      $display("FAIL stall_release got %b required 010", {bus.out_valid, bus.in_ready, bus.busy});
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_op(8'h55, 8'hAA);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.nib_a, bus.nib_b} !== 11'b010_0000_0000) begin
      errors++;
      $display("FAIL midreset_state got %b required 01000000000", {bus.out_valid, bus.in_ready, bus.busy, bus.nib_a, bus.nib_b});
    end
    bus.out_ready = 1'b1;
    start_op(8'h03, 8'h05);
    repeat (4) tick();
    checks++;
    if ({bus.out_valid, bus.out_prod} !== {1'b1, 16'h000F}) begin
      errors++;
      $display("FAIL midreset_next got %b/%h required 1/000f", bus.out_valid, bus.out_prod);
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] expq [$];
    logic [15:0] e;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit acc_now;
    bus.in_a      = 8'($urandom_range(0, 255));
    bus.in_b      = 8'($urandom_range(0, 255));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'($urandom_range(0, 1));
    while ((sent < 20 || got < 20) && cyc < 2000) begin
      acc_now = bus.in_valid && bus.in_ready;
      if (acc_now) begin
        expq.push_back(16'(bus.in_a) * 16'(bus.in_b));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got %h required none", bus.out_prod);
        end else begin
          e = expq.pop_front();
          if (bus.out_prod !== e) begin
            errors++;
            $display("FAIL b2b_prod item %0d got %h required %h", got, bus.out_prod, e);
          end
        end
        got++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (sent < 20) begin
          bus.in_a = 8'($urandom_range(0, 255));
          bus.in_b = 8'($urandom_range(0, 255));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    if (got != 20 || expq.size() != 0 || cyc >= 2000) begin
      errors++;
      $display("FAIL b2b_count got %0d results (%0d pending, %0d cycles) required 20", got, expq.size(), cyc);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_full_ones();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
